// File: rtl/pio_input_conditioner.sv
// pio_input_conditioner
//   Conditions raw board KEY/SW pins into the two 32-bit words read by the host
//   through the push_buttons and switches input PIOs. Every pin gets a two-flop
//   synchroniser and a debounce counter. Buttons also get sticky press-event
//   bits, which the host clears through an output PIO.
//
// Ports
//   clk                system clock (same domain as the PIO slaves)
//   reset              synchronous, active-high reset
//   buttons_raw        asynchronous button pins (polarity set by BUTTON_ACTIVE_LOW)
//   switches_raw       asynchronous slide-switch pins
//   evt_clear          level from the host; a 1 on bit i clears event bit i
//   push_buttons_word  {|evt, 0.., evt @16, 0.., pressed levels @0}
//   switches_word      stable switch levels, zero-extended
module pio_input_conditioner #(
    parameter int NUM_BUTTONS       = 4,
    parameter int NUM_SWITCHES      = 18,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1,
    parameter int CNT_W             = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BUTTONS-1:0]  buttons_raw,
    input  logic [NUM_SWITCHES-1:0] switches_raw,
    input  logic [NUM_BUTTONS-1:0]  evt_clear,
    output logic [31:0]             push_buttons_word,
    output logic [31:0]             switches_word
);

    // Buttons and switches share one pipeline: buttons occupy the low bits.
    // After normalisation the inactive level is 0 for every bit, so one reset
    // value serves both groups.
    localparam int NUM_BITS = NUM_BUTTONS + NUM_SWITCHES;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] buttons_norm;
    logic [NUM_BITS-1:0]    pins_norm;
    logic [NUM_BITS-1:0]    sync1;
    logic [NUM_BITS-1:0]    sync2;
    logic [NUM_BITS-1:0]    stable;
    logic [CNT_W-1:0]       cnt [NUM_BITS];
    logic [NUM_BUTTONS-1:0] stable_d;
    logic [NUM_BUTTONS-1:0] evt;
    logic [NUM_BUTTONS-1:0] press;

    assign buttons_norm = BUTTON_ACTIVE_LOW ? ~buttons_raw : buttons_raw;
    assign pins_norm    = {switches_raw, buttons_norm};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < NUM_BITS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= pins_norm;
            sync2 <= sync1;
            for (int i = 0; i < NUM_BITS; i++) begin
                // Any return to the accepted level restarts the count, so only
                // a level held for DEBOUNCE_CYCLES consecutive samples is taken.
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_TC) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = stable[NUM_BUTTONS-1:0] & ~stable_d;

    // A press on the same edge as a clear wins, so the host never loses a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= '0;
            evt      <= '0;
        end else begin
            stable_d <= stable[NUM_BUTTONS-1:0];
            evt      <= press | (evt & ~evt_clear);
        end
    end

    // Both words are built only from registers, so no raw pin reaches the host
    // combinationally.
    always_comb begin
        push_buttons_word                       = '0;
        push_buttons_word[NUM_BUTTONS-1:0]      = stable[NUM_BUTTONS-1:0];
        push_buttons_word[16+NUM_BUTTONS-1:16]  = evt;
        push_buttons_word[31]                   = |evt;
        switches_word                           = '0;
        switches_word[NUM_SWITCHES-1:0]         = stable[NUM_BITS-1:NUM_BUTTONS];
    end

endmodule
